// File: rtl/matrix_mac_engine.sv
// Matrix multiply-accumulate engine: C = A x B (or C += A x B), one MAC per cycle.
// A, B, C and the control registers are accessed through the slave bus.
module matrix_mac_engine #(
    parameter int DW   = 32,
    parameter int N    = 4,
    parameter int DIMW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          S_sel,
    input  logic          S_wr,
    input  logic [7:0]    S_address,
    input  logic [DW-1:0] S_din,
    output logic [DW-1:0] S_dout,
    output logic          m_interrupt,
    output logic          busy,
    output logic          done,
    output logic [1:0]    o_dbg_state
);
    // Bus handshake: a transfer happens on every rising edge where S_sel is
    // high; S_wr selects write (sampled at the edge) or read (S_dout combinational).
    localparam int NN = N * N;
    localparam int IW = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_a [0:31];
    logic [DW-1:0]   r_b [0:31];
    logic [DW-1:0]   r_c [0:31];
    logic [DW-1:0]   r_acc;
    logic [DIMW-1:0] r_dim, r_i, r_j, r_k;
    logic            r_int_en, r_mode, r_error, r_done, r_irq;

    logic            w_wr, w_rd, w_busy;
    logic [IW-1:0]   w_idx;
    logic [2:0]      w_win;
    logic            w_idx_ok;
    logic            w_start, w_clear, w_stat_wr, w_go, w_dim_ok;
    logic [DIMW-1:0] w_dim_m1;
    logic            w_last_k, w_last_j, w_last_i, w_finish;
    logic [IW-1:0]   w_ij, w_ik, w_kj;
    logic [DW-1:0]   w_prod, w_base, w_sum;
    logic            w_done_nxt, w_err_nxt, w_int_en_nxt;
    logic [DW-1:0]   w_rdata;

    assign w_wr      = S_sel & S_wr;
    assign w_rd      = S_sel & ~S_wr;
    assign w_busy    = (r_state == ST_RUN);
    assign w_idx     = S_address[4:0];
    assign w_win     = S_address[7:5];
    assign w_idx_ok  = (32'(w_idx) < NN);

    assign w_start   = w_wr && (S_address == 8'h00) && S_din[0];
    assign w_clear   = w_wr && (S_address == 8'h01) && S_din[0];
    assign w_stat_wr = w_wr && (S_address == 8'h05);
    assign w_go      = w_start && !w_busy;
    assign w_dim_ok  = (r_dim != '0) && (32'(r_dim) <= N);

    assign w_dim_m1  = r_dim - DIMW'(1);
    assign w_last_k  = (r_k == w_dim_m1);
    assign w_last_j  = (r_j == w_dim_m1);
    assign w_last_i  = (r_i == w_dim_m1);
    assign w_finish  = w_busy && w_last_k && w_last_j && w_last_i;

    // Physical stride is always N, regardless of the runtime dimension.
    assign w_ij   = IW'(r_i) * IW'(N) + IW'(r_j);
    assign w_ik   = IW'(r_i) * IW'(N) + IW'(r_k);
    assign w_kj   = IW'(r_k) * IW'(N) + IW'(r_j);
    assign w_prod = r_a[w_ik] * r_b[w_kj];
    assign w_base = (r_k == '0) ? (r_mode ? r_c[w_ij] : '0) : r_acc;
    assign w_sum  = w_base + w_prod;

    // Next-state status flags; the interrupt is registered from these so it
    // moves in the same cycle as done/error.
    always_comb begin
        w_done_nxt = r_done;
        w_err_nxt  = r_error;
        if (w_clear) begin
            w_done_nxt = 1'b0;
            w_err_nxt  = 1'b0;
        end else if (w_go) begin
            w_done_nxt = !w_dim_ok;
            w_err_nxt  = !w_dim_ok;
        end else if (w_finish) begin
            w_done_nxt = 1'b1;
        end else if (w_stat_wr) begin
            w_done_nxt = 1'b0;
            w_err_nxt  = 1'b0;
        end
    end

    assign w_int_en_nxt = (w_wr && (S_address == 8'h02)) ? S_din[0] : r_int_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_dim    <= DIMW'(N);
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_int_en <= 1'b0;
            r_mode   <= 1'b0;
            r_error  <= 1'b0;
            r_done   <= 1'b0;
            r_irq    <= 1'b0;
            for (int n = 0; n < 32; n++) begin
                r_a[n] <= '0;
                r_b[n] <= '0;
                r_c[n] <= '0;
            end
        end else begin
            r_done   <= w_done_nxt;
            r_error  <= w_err_nxt;
            r_int_en <= w_int_en_nxt;
            r_irq    <= w_int_en_nxt & (w_done_nxt | w_err_nxt);

            if (!w_busy && w_wr && (S_address == 8'h03)) r_dim  <= S_din[DIMW-1:0];
            if (!w_busy && w_wr && (S_address == 8'h04)) r_mode <= S_din[0];
            if (!w_busy && w_wr && (w_win == 3'd1) && w_idx_ok) r_a[w_idx] <= S_din;
            if (!w_busy && w_wr && (w_win == 3'd2) && w_idx_ok) r_b[w_idx] <= S_din;

            if (w_clear) begin
                r_state <= ST_IDLE;
                r_i     <= '0;
                r_j     <= '0;
                r_k     <= '0;
                for (int n = 0; n < 32; n++) r_c[n] <= '0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (w_go) begin
                            r_state <= w_dim_ok ? ST_RUN : ST_DONE;
                            r_i     <= '0;
                            r_j     <= '0;
                            r_k     <= '0;
                        end else if ((r_state == ST_DONE) && w_stat_wr) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        r_acc <= w_sum;
                        if (w_last_k) begin
                            r_c[w_ij] <= w_sum;
                            r_k       <= '0;
                            if (w_last_j) begin
                                r_j <= '0;
                                if (w_last_i) r_state <= ST_DONE;
                                else          r_i     <= r_i + DIMW'(1);
                            end else begin
                                r_j <= r_j + DIMW'(1);
                            end
                        end else begin
                            r_k <= r_k + DIMW'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (S_address)
            8'h02: w_rdata[0]      = r_int_en;
            8'h03: w_rdata[DIMW-1:0] = r_dim;
            8'h04: w_rdata[0]      = r_mode;
            8'h05: w_rdata[2:0]    = {r_error, r_done, w_busy};
            default: begin
                if (w_idx_ok) begin
                    case (w_win)
                        3'd1:    w_rdata = r_a[w_idx];
                        3'd2:    w_rdata = r_b[w_idx];
                        3'd3:    w_rdata = r_c[w_idx];
                        default: w_rdata = '0;
                    endcase
                end
            end
        endcase
    end

    assign S_dout      = w_rd ? w_rdata : '0;
    assign m_interrupt = r_irq;
    assign busy        = w_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule
